sort_mem: RTL and testbench
===========================

SORT_MEM -- requirements
Module: sort_mem

Interface
REQ-001 SHALL have parameter DW, default 8, data width in bits.
REQ-002 SHALL have parameter AW, default 3, address width; depth = 2**AW (8).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port add  input  AW  bus address from the sort controller.
REQ-006 SHALL have port wr  input  1  bus direction; 0 = controller drives data (write), 1 = memory drives data (read).
REQ-007 SHALL have port data  inout  DW  shared bidirectional bus.
REQ-008 SHALL have port ld_en  input  1  host preload strobe.
REQ-009 SHALL have port ld_add  input  AW  host preload address.
REQ-010 SHALL have port ld_data  input  DW  host preload data.
REQ-011 SHALL have port rd_add  input  AW  host readback address.
REQ-012 SHALL have port rd_data  output  DW  host readback data, registered.
REQ-013 SHALL have port wr_cnt  output  16  count of accepted bus write cycles.
REQ-014 SHALL have port sorted  output  1  contents non-increasing from address 0 to 7.

Function
REQ-015 SHALL hold DEPTH x DW storage words mem[0..DEPTH-1].
REQ-016 SHALL register the bus read word every cycle: rd_q <= mem[add]; read latency is 1 cycle from add change.
REQ-017 SHALL drive data = rd_q when wr = 1, and high-Z when wr = 0, combinationally from wr (no turnaround cycle).
REQ-018 SHALL, on a rising edge with wr = 0 and ld_en = 0, write mem[add] <= data and increment wr_cnt.
REQ-019 SHALL accept repeated writes to the same address across consecutive cycles; each is an accepted write cycle and the last value wins.
REQ-020 SHALL, on a rising edge with ld_en = 1, write mem[ld_add] <= ld_data regardless of wr.
REQ-021 SHALL give ld_en priority over a simultaneous bus write: the bus write is dropped and wr_cnt does not increment.
REQ-022 SHALL make a write to address a visible on data no earlier than the cycle after the write edge (read-after-write through rd_q, no bypass).
REQ-023 SHALL saturate wr_cnt at 16'hFFFF; no wrap-around.
REQ-024 SHALL register rd_data <= mem[rd_add] every cycle; latency 1 cycle, independent of bus activity.
REQ-025 SHALL use only unsigned DW-bit values; addresses never exceed DEPTH-1, so no out-of-range case exists.

Reset
REQ-026 SHALL, on a rising edge with rst = 0, clear all mem words, rd_q, rd_data and wr_cnt to 0 and sorted to 0; the bus is high-Z while wr = 0 and drives 0 while wr = 1.
REQ-027 SHALL give reset priority over ld_en and bus writes in the same cycle; a reset mid-sort discards all in-progress writes.

Configuration
REQ-028 SHALL, with macro SORT_MEM_ORDER_CHECK_EN defined, update sorted every cycle: sorted <= 1 iff mem[k] >= mem[k+1] for all k in 0..DEPTH-2, using the pre-edge contents (1-cycle lag).
REQ-029 SHALL, without SORT_MEM_ORDER_CHECK_EN, tie sorted to constant 0 and instantiate no comparator logic.

Structure
REQ-030 SHALL take DW, AW and DEPTH defaults, plus the wr encodings WR_WRITE = 0 and WR_READ = 1, from shared package sort_pkg, which the sort controller also uses.
REQ-031 SHALL implement the order check in one sub-module, sort_mem_order_chk (combinational compare of the DEPTH words), instantiated only under SORT_MEM_ORDER_CHECK_EN.

Verification
REQ-032 SHALL cover: preload 0..7 with 8'h10,20,30,40,50,60,70,80, wr = 1, add = 3 -> data = 8'h40 one cycle later; rd_add = 7 -> rd_data = 8'h80.
REQ-033 SHALL cover: wr = 0, add = 2, data driven 8'hAA for 3 cycles -> mem[2] = 8'hAA, wr_cnt = 3, data high-Z from memory during those cycles.
REQ-034 SHALL cover: ld_en = 1 (ld_add = 5, ld_data = 8'h11) in the same cycle as wr = 0, add = 5, data = 8'h99 -> mem[5] = 8'h11, wr_cnt unchanged.
REQ-035 SHALL cover: sort controller attached, preload 3,9,1,7,0,8,2,5, start pulsed -> after done, rd_data over 0..7 = 9,8,7,5,3,2,1,0 and sorted = 1 (with macro defined).
REQ-036 SHALL cover: rst = 0 asserted mid-sort for one cycle -> next cycle all mem = 0, wr_cnt = 0, sorted = 0; one cycle later sorted = 1 (all zeros, macro defined).
REQ-037 SHALL cover: force wr_cnt to 16'hFFFE, then 3 bus write cycles -> wr_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared definitions for the sort memory and the sort controller that drives its bus.
package sort_pkg;

  localparam int unsigned DW_DEF    = 8;
  localparam int unsigned AW_DEF    = 3;
  localparam int unsigned DEPTH_DEF = 1 << AW_DEF;

  // Bus direction encodings seen on the wr line.
  localparam logic WR_WRITE = 1'b0;
  localparam logic WR_READ  = 1'b1;

  // One bus beat as issued by the sort controller.
  typedef struct packed {
    logic              wr;
    logic [AW_DEF-1:0] add;
    logic [DW_DEF-1:0] data;
  } bus_beat_t;

endpackage

// File: rtl/sort_mem_order_chk.sv
// Combinational check that the stored words are non-increasing from word 0 upwards.
module sort_mem_order_chk #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic [DEPTH*DW-1:0] words_i,
  output logic                ordered_o
);

  always_comb begin
    ordered_o = 1'b1;
    for (int k = 0; k < DEPTH - 1; k++) begin
      if (words_i[k*DW +: DW] < words_i[(k+1)*DW +: DW]) ordered_o = 1'b0;
    end
  end

endmodule

// File: rtl/sort_mem.sv
// Sort working memory: shared bidirectional bus for the sort controller plus host preload/readback.
// Define SORT_MEM_ORDER_CHECK_EN to build the registered 'sorted' order flag.
module sort_mem
  import sort_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] add,
  input  logic          wr,
  inout  wire  [DW-1:0] data,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_add,
  input  logic [DW-1:0] ld_data,
  input  logic [AW-1:0] rd_add,
  output logic [DW-1:0] rd_data,
  output logic [15:0]   wr_cnt,
  output logic          sorted
);

  localparam int unsigned DEPTH   = 1 << AW;
  localparam int unsigned CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DW-1:0]    rd_q;
  logic [DW-1:0]    rd_data_q;
  logic [CNT_W-1:0] wr_cnt_q;
  logic [CNT_W-1:0] wr_cnt_d;
  logic             bus_we_c;

  // Host preload wins over a bus write in the same cycle; the dropped write is not counted.
  always_comb begin
    bus_we_c = (wr == WR_WRITE) && !ld_en;
    wr_cnt_d = wr_cnt_q;
    if (bus_we_c && (wr_cnt_q != CNT_MAX)) wr_cnt_d = wr_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q      <= '0;
      rd_data_q <= '0;
      wr_cnt_q  <= '0;
    end else begin
      rd_q      <= mem_q[add];
      rd_data_q <= mem_q[rd_add];
      wr_cnt_q  <= wr_cnt_d;
      if (ld_en)         mem_q[ld_add] <= ld_data;
      else if (bus_we_c) mem_q[add]    <= data;
    end
  end

  // No turnaround: the memory releases the bus in the same cycle wr drops.
  assign data    = (wr == WR_READ) ? rd_q : {DW{1'bz}};
  assign rd_data = rd_data_q;
  assign wr_cnt  = wr_cnt_q;

`ifdef SORT_MEM_ORDER_CHECK_EN
  logic [DEPTH*DW-1:0] mem_flat_c;
  logic                ordered_c;
  logic                sorted_q;

  always_comb begin
    mem_flat_c = '0;
    for (int i = 0; i < DEPTH; i++) mem_flat_c[i*DW +: DW] = mem_q[i];
  end

  sort_mem_order_chk #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_order_chk (
    .words_i   (mem_flat_c),
    .ordered_o (ordered_c)
  );

  // Flag reflects the contents before each edge, so it lags a write by one cycle.
  always_ff @(posedge clk) begin
    if (!rst) sorted_q <= 1'b0;
    else      sorted_q <= ordered_c;
  end

  assign sorted = sorted_q;
`else
  assign sorted = 1'b0;
`endif

endmodule

// File: tb/tb_sort_mem.sv
// Directed self-checking bench for sort_mem; a task-level sort controller drives the shared bus.
module tb_sort_mem;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;

`ifdef SORT_MEM_ORDER_CHECK_EN
  localparam logic EXP_SORTED = 1'b1;
`else
  localparam logic EXP_SORTED = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [AW-1:0] add;
  logic          wr;
  wire  [DW-1:0] data;
  logic          ld_en;
  logic [AW-1:0] ld_add;
  logic [DW-1:0] ld_data;
  logic [AW-1:0] rd_add;
  logic [DW-1:0] rd_data;
  logic [15:0]   wr_cnt;
  logic          sorted;

  logic          tb_drv;
  logic [DW-1:0] tb_data;

  int n_chk;
  int n_fail;

  assign data = tb_drv ? tb_data : {DW{1'bz}};

  sort_mem #(.DW(DW), .AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .add     (add),
    .wr      (wr),
    .data    (data),
    .ld_en   (ld_en),
    .ld_add  (ld_add),
    .ld_data (ld_data),
    .rd_add  (rd_add),
    .rd_data (rd_data),
    .wr_cnt  (wr_cnt),
    .sorted  (sorted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [DW-1:0] v [8]);
    for (int i = 0; i < 8; i++) begin
      ld_en   = 1'b1;
      ld_add  = AW'(i);
      ld_data = v[i];
      step();
    end
    ld_en = 1'b0;
  endtask

  task automatic bus_read(input int a, output logic [DW-1:0] v);
    wr     = 1'b1;
    tb_drv = 1'b0;
    add    = AW'(a);
    step();
    v = data;
  endtask

  task automatic bus_write(input int a, input logic [DW-1:0] v);
    wr      = 1'b0;
    add     = AW'(a);
    tb_data = v;
    tb_drv  = 1'b1;
    step();
    tb_drv  = 1'b0;
    wr      = 1'b1;
  endtask

  // Bubble sort to descending order over the bus, stopping after max_cmp compares.
  task automatic run_sort(input int max_cmp);
    int n;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    n = 0;
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 7 - i; j++) begin
        if (n >= max_cmp) return;
        n++;
        bus_read(j, a);
        bus_read(j + 1, b);
        if (a < b) begin
          bus_write(j, b);
          bus_write(j + 1, a);
        end
      end
    end
  endtask

  logic [DW-1:0] vec_ramp [8];
  logic [DW-1:0] vec_sort [8];
  logic [DW-1:0] exp_sort [8];

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    vec_ramp = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    vec_sort = '{8'd3, 8'd9, 8'd1, 8'd7, 8'd0, 8'd8, 8'd2, 8'd5};
    exp_sort = '{8'd9, 8'd8, 8'd7, 8'd5, 8'd3, 8'd2, 8'd1, 8'd0};
    rst = 1'b0; wr = 1'b1; add = '0; ld_en = 1'b0; ld_add = '0; ld_data = '0;
    rd_add = '0; tb_drv = 1'b0; tb_data = '0;

    // Reset state
    step(); step();
    check("rst_wr_cnt", 32'(wr_cnt), 32'h0);
    check("rst_rd_data", 32'(rd_data), 32'h0);
    check("rst_sorted", 32'(sorted), 32'h0);
    check("rst_bus_read", 32'(data), 32'h0);
    rst = 1'b1;

    // Preload ramp, then bus read of word 3 and host readback of word 7
    preload(vec_ramp);
    wr = 1'b1; add = 3'd3; rd_add = 3'd7;
    step();
    check("bus_read_3", 32'(data), 32'h40);
    check("host_read_7", 32'(rd_data), 32'h80);
    check("preload_no_count", 32'(wr_cnt), 32'h0);

    // Three back-to-back bus writes to word 2; memory must keep off the bus
    wr = 1'b0; add = 3'd2; tb_data = 8'hAA; tb_drv = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("bus_hiz_on_write", 32'(data), 32'hAA);
    end
    check("wr_cnt_3", 32'(wr_cnt), 32'd3);
    tb_drv = 1'b0; wr = 1'b1; rd_add = 3'd2;
    step();
    check("raw_bus_2", 32'(data), 32'hAA);
    check("raw_host_2", 32'(rd_data), 32'hAA);

    // Preload collides with bus write to the same word
    ld_en = 1'b1; ld_add = 3'd5; ld_data = 8'h11;
    wr = 1'b0; add = 3'd5; tb_data = 8'h99; tb_drv = 1'b1;
    step();
    ld_en = 1'b0; tb_drv = 1'b0; wr = 1'b1; rd_add = 3'd5;
    step();
    check("collide_bus_5", 32'(data), 32'h11);
    check("collide_host_5", 32'(rd_data), 32'h11);
    check("collide_wr_cnt", 32'(wr_cnt), 32'd3);

    // Full sort through the bus
    preload(vec_sort);
    step();
    check("unsorted_flag", 32'(sorted), 32'h0);
    run_sort(1000);
    for (int i = 0; i < 8; i++) begin
      rd_add = AW'(i);
      step();
      check($sformatf("sorted_word_%0d", i), 32'(rd_data), 32'(exp_sort[i]));
    end
    check("sorted_flag", 32'(sorted), 32'(EXP_SORTED));

    // Reset mid-sort, colliding with a preload and a bus write
    preload(vec_sort);
    run_sort(3);
    rst = 1'b0;
    ld_en = 1'b1; ld_add = 3'd0; ld_data = 8'hFF;
    wr = 1'b0; add = 3'd1; tb_data = 8'h77; tb_drv = 1'b1;
    step();
    check("midrst_wr_cnt", 32'(wr_cnt), 32'h0);
    check("midrst_sorted", 32'(sorted), 32'h0);
    rst = 1'b1; ld_en = 1'b0; tb_drv = 1'b0; wr = 1'b1; rd_add = 3'd0;
    step();
    check("midrst_sorted_zero", 32'(sorted), 32'(EXP_SORTED));
    check("midrst_bus_1", 32'(data), 32'h0);
    check("midrst_word_0", 32'(rd_data), 32'h0);
    for (int i = 1; i < 8; i++) begin
      rd_add = AW'(i);
      step();
      check($sformatf("midrst_word_%0d", i), 32'(rd_data), 32'h0);
    end

    // Counter saturation
    dut.wr_cnt_q = 16'hFFFE;
    for (int c = 0; c < 3; c++) bus_write(c, 8'h5A);
    check("wr_cnt_sat", 32'(wr_cnt), 32'h0000FFFF);
    bus_write(4, 8'hA5);
    check("wr_cnt_sat_hold", 32'(wr_cnt), 32'h0000FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
